branch_seq_ctrl: RTL and testbench
==================================

Name: branch_seq_ctrl

Overview:
- Sequences the shared immediate-extension datapath between the normal decode path and branch-target calculation in the pipelined CPU.
- On a decoded branch it stalls decode, forces the branch immediate format, and computes the target as PC + PC_OFFSET + extended immediate.
- It then hands the redirect to fetch with a valid/ready handshake, writes the link register if required, and flushes the pipeline for a fixed number of cycles.

Parameters:
- WIDTH, 48, datapath/PC/immediate width.
- PC_OFFSET, 8, constant added to captured PC for the branch target.
- LINK_OFFSET, 4, constant added to captured PC for the link value.
- FLUSH_CYCLES, 2, cycles flush stays high after redirect acceptance (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block can accept; decode stalls when low.
- is_branch  in  1  presented instruction is a branch.
- is_link  in  1  branch with link.
- cond_pass  in  1  condition check result for presented instruction.
- pc  in  WIDTH  PC of presented instruction.
- imm_src_req  in  2  ImmSrc requested by main decoder.
- imm_src  out  2  ImmSrc driven to the extension unit.
- ext_imm  in  WIDTH  extension unit result (combinational from imm_src).
- redirect_valid  out  1  target PC offered to fetch.
- redirect_ready  in  1  fetch accepts target.
- redirect_pc  out  WIDTH  branch target.
- link_we  out  1  one-cycle link register write strobe.
- link_data  out  WIDTH  link value.
- flush  out  1  squash younger pipeline stages.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - On rst_n=0 at a clk edge: state=IDLE, every register cleared.
  - Outputs after reset: in_ready=1, imm_src=imm_src_req (IDLE passthrough), redirect_valid=0, redirect_pc=0, link_we=0, link_data=0, flush=0.
- FSM states: IDLE, CALC, REDIRECT, FLUSH.
- IDLE:
  - in_ready=1; imm_src=imm_src_req (decode owns the extension unit).
  - in_valid & is_branch at the edge: capture pc_q=pc, link_q=is_link, cond_q=cond_pass; go to CALC.
  - in_valid & !is_branch: no state change.
- CALC (exactly 1 cycle):
  - in_ready=0; imm_src forced to 2'b10.
  - At the edge: target_q = pc_q + PC_OFFSET + ext_imm, modulo 2^WIDTH (wrap, no overflow flag).
  - cond_q=1: go to REDIRECT. cond_q=0: go to IDLE, no redirect, no link, no flush.
- REDIRECT:
  - in_ready=0; imm_src=2'b10; redirect_valid=1; redirect_pc=target_q, held stable while waiting.
  - redirect_ready=1 in a cycle: the transfer completes. In that same cycle link_we=link_q and link_data=pc_q+LINK_OFFSET (mod 2^WIDTH). Load the flush counter with FLUSH_CYCLES; go to FLUSH.
  - redirect_ready=0: stay; no timeout.
- FLUSH:
  - flush=1; in_ready=0; imm_src=imm_src_req; the counter decrements each cycle.
  - On the cycle the counter reaches 1: go to IDLE. flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after acceptance.
- Latencies:
  - Branch acceptance to redirect_valid: 2 edges (IDLE→CALC→REDIRECT).
  - Not-taken branch: back in IDLE 2 edges after acceptance.
- Boundary conditions:
  - Back-to-back branches: no new instruction is accepted outside IDLE; decode holds the next one.
  - in_valid must not be assumed dropped while in_ready=0.
  - Reset asserted in any state: abandon immediately. No redirect, link write or flush may leak on the cycle after reset.
  - redirect_ready high outside REDIRECT: ignored.
  - FLUSH_CYCLES counter width: $clog2(FLUSH_CYCLES+1).
- link_we is never high outside the REDIRECT acceptance cycle.

Decomposition:
- Shared package cpu_pkg:
  - typedef enum for ImmSrc: IMM8=2'b00, IMM12=2'b01, BR24=2'b10.
  - FSM state enum br_state_t.
  - WIDTH constant.
- One natural sub-module: branch_target_add, the registered WIDTH-bit adder pc + offset + imm with wrap. Everything else stays in the FSM body.

Test Plan:
- Reset, then a non-branch with imm_src_req=01 → imm_src=01, in_ready=1, no redirect/flush.
- Taken branch: pc=0x100, instr imm24=0x000010 (ext_imm=0x40), redirect_ready=1 → redirect_pc=0x148 two edges later; flush high for 2 cycles; in_ready back to 1 after.
- Branch-link, pc=0x200, ext_imm=−8 (0xFFFFFFFFFFF8), redirect_ready low 3 cycles then high → redirect_pc=0x200 held stable; link_we pulses once with link_data=0x204 in the acceptance cycle.
- Not-taken branch (cond_pass=0) → in_ready low 1 cycle (CALC), imm_src=10 during CALC, no redirect_valid/link_we/flush.
- Wrap: pc=0xFFFFFFFFFFFC, ext_imm=0 → redirect_pc=0x000000000004.
- rst_n low during REDIRECT and again during FLUSH → next cycle state IDLE, redirect_valid=0, flush=0, link_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU decode/branch path.
//   - CPU_WIDTH  : default datapath / PC / immediate width
//   - imm_src_t  : ImmSrc encodings understood by the immediate-extension unit
//   - br_state_t : states of the branch sequencing controller
package cpu_pkg;

  localparam int CPU_WIDTH = 48;

  typedef enum logic [1:0] {
    IMM8  = 2'b00,
    IMM12 = 2'b01,
    BR24  = 2'b10
  } imm_src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CALC     = 2'b01,
    REDIRECT = 2'b10,
    FLUSH    = 2'b11
  } br_state_t;

endpackage

// File: rtl/branch_target_add.sv
// Registered three-operand adder used for branch-target generation.
// The sum wraps modulo 2^WIDTH; there is no overflow indication.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset, clears the held sum
//   load  - capture base + OFFSET + imm on this edge
//   base  - captured PC of the branch
//   imm   - extended immediate (two's complement; wraparound makes
//           signed and unsigned addition identical here)
//   sum   - registered target, held until the next load
module branch_target_add #(
  parameter int WIDTH  = 48,
  parameter int OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_p1;

  // Modular add: operands and result share one width, so carries out of
  // the top bit are simply discarded.
  function automatic logic [WIDTH-1:0] wrap_add3(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    return a + b + c;
  endfunction

  // Stage p0 -> p1: operands sampled during CALC, target held afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1 <= '0;
    end else if (load) begin
      sum_p1 <= wrap_add3(base, WIDTH'(OFFSET), imm);
    end
  end

  assign sum = sum_p1;

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller.
// Shares the immediate-extension unit between normal decode and branch
// target generation. A decoded branch stalls decode, forces the BR24
// immediate format for one cycle so the target can be computed, then offers
// the target to fetch over a valid/ready handshake. On acceptance the link
// register is written (for branch-with-link) and the younger pipeline stages
// are flushed for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid / in_ready     - decode handshake; decode stalls while in_ready=0
//   is_branch, is_link      - presented instruction is a branch / branch-link
//   cond_pass               - condition result for the presented instruction
//   pc                      - PC of the presented instruction
//   imm_src_req / imm_src   - ImmSrc from main decoder / ImmSrc to extender
//   ext_imm                 - extender output (combinational from imm_src)
//   redirect_valid/_ready   - target handshake towards fetch
//   redirect_pc             - branch target
//   link_we, link_data      - one-cycle link register write
//   flush                   - squash younger pipeline stages
module branch_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH        = cpu_pkg::CPU_WIDTH,
  parameter int PC_OFFSET    = 8,
  parameter int LINK_OFFSET  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             is_link,
  input  logic             cond_pass,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       imm_src_req,
  output logic [1:0]       imm_src,
  input  logic [WIDTH-1:0] ext_imm,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             link_we,
  output logic [WIDTH-1:0] link_data,
  output logic             flush
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  br_state_t        state_q;
  br_state_t        state_d;
  logic [WIDTH-1:0] pc_q;
  logic             link_q;
  logic             cond_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [WIDTH-1:0] target_q;

  logic accept_br;
  logic calc_load;
  logic redirect_fire;
  logic flush_last;

  // A new instruction is only ever taken in IDLE; in every other state
  // decode is stalled and holds whatever it is presenting.
  assign accept_br     = (state_q == IDLE) && in_valid && is_branch;
  assign calc_load     = (state_q == CALC);
  assign redirect_fire = (state_q == REDIRECT) && redirect_ready;
  assign flush_last    = (flush_cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_br) begin
          state_d = CALC;
        end
      end
      CALC: begin
        // Not-taken branches go straight back without touching fetch.
        state_d = cond_q ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: branch capture, sequencing state and flush counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      link_q      <= 1'b0;
      cond_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_br) begin
        pc_q   <= pc;
        link_q <= is_link;
        cond_q <= cond_pass;
      end
      if (redirect_fire) begin
        flush_cnt_q <= CNT_W'(FLUSH_CYCLES);
      end else if (state_q == FLUSH) begin
        flush_cnt_q <= flush_cnt_q - CNT_W'(1);
      end
    end
  end

  // Stage p0 -> p1: target computed while the extender is forced to BR24
  branch_target_add #(
    .WIDTH  (WIDTH),
    .OFFSET (PC_OFFSET)
  ) u_target_add (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (calc_load),
    .base  (pc_q),
    .imm   (ext_imm),
    .sum   (target_q)
  );

  // The extender is borrowed for the branch from CALC until fetch takes the
  // target; decode owns it again during the flush.
  always_comb begin
    in_ready       = 1'b0;
    imm_src        = imm_src_req;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      CALC: begin
        imm_src = BR24;
      end
      REDIRECT: begin
        imm_src        = BR24;
        redirect_valid = 1'b1;
      end
      FLUSH: begin
        flush = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // target_q only changes on a CALC edge, so it is stable while fetch stalls.
  assign redirect_pc = target_q;

  // Link write is a single strobe on the handshake cycle. The data bus is
  // zeroed otherwise so no stale link value is visible after reset.
  assign link_we   = redirect_fire && link_q;
  assign link_data = redirect_fire ? (pc_q + WIDTH'(LINK_OFFSET)) : '0;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
module tb_branch_seq_ctrl;

  localparam int W  = 48;
  localparam int FL = 2;

  logic         clk            = 1'b0;
  logic         rst_n          = 1'b0;
  logic         in_valid       = 1'b0;
  logic         is_branch      = 1'b0;
  logic         is_link        = 1'b0;
  logic         cond_pass      = 1'b0;
  logic         redirect_ready = 1'b0;
  logic [W-1:0] pc             = '0;
  logic [1:0]   imm_src_req    = 2'b00;
  logic [23:0]  instr          = '0;

  logic         in_ready;
  logic [1:0]   imm_src;
  logic [W-1:0] ext_imm;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         link_we;
  logic [W-1:0] link_data;
  logic         flush;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_seq_ctrl #(
    .WIDTH        (W),
    .PC_OFFSET    (8),
    .LINK_OFFSET  (4),
    .FLUSH_CYCLES (FL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .is_branch      (is_branch),
    .is_link        (is_link),
    .cond_pass      (cond_pass),
    .pc             (pc),
    .imm_src_req    (imm_src_req),
    .imm_src        (imm_src),
    .ext_imm        (ext_imm),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_data      (link_data),
    .flush          (flush)
  );

  // Immediate-extension unit stand-in: combinational from imm_src.
  function automatic logic [W-1:0] br_ext(input logic [23:0] f);
    return {{22{f[23]}}, f, 2'b00};
  endfunction

  always_comb begin
    ext_imm = '0;
    case (imm_src)
      2'b10:   ext_imm = br_ext(instr);
      2'b01:   ext_imm = {36'd0, instr[11:0]};
      default: ext_imm = {40'd0, instr[7:0]};
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a branch in flight is described by its age in cycles
  // since acceptance and the age at which fetch took the target.
  bit           started = 1'b0;
  bit           busy    = 1'b0;
  int           age     = 0;
  int           acc_age = -1;
  logic [W-1:0] m_pc     = '0;
  logic [W-1:0] m_target = '0;
  bit           m_link  = 1'b0;
  bit           m_taken = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      started <= 1'b1;
      busy    <= 1'b0;
      age     <= 0;
      acc_age <= -1;
    end else if (!busy) begin
      if (in_valid && is_branch) begin
        busy    <= 1'b1;
        age     <= 1;
        acc_age <= -1;
        m_pc    <= pc;
        m_link  <= is_link;
        m_taken <= cond_pass;
      end
    end else if (age == 1) begin
      m_target <= m_pc + 48'd8 + br_ext(instr);
      if (m_taken) age <= 2;
      else busy <= 1'b0;
    end else if (acc_age < 0) begin
      if (redirect_ready) acc_age <= age;
      age <= age + 1;
    end else begin
      age <= age + 1;
      if (age + 1 > acc_age + FL) busy <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    logic         e_rdy;
    logic [1:0]   e_imm;
    logic         e_rv;
    logic         e_lw;
    logic         e_fl;
    logic [W-1:0] e_ld;
    if (started) begin
      e_rdy = 1'b1;
      e_imm = imm_src_req;
      e_rv  = 1'b0;
      e_lw  = 1'b0;
      e_fl  = 1'b0;
      e_ld  = '0;
      if (busy) begin
        e_rdy = 1'b0;
        if (age == 1) begin
          e_imm = 2'b10;
        end else if (acc_age < 0) begin
          e_imm = 2'b10;
          e_rv  = 1'b1;
          if (redirect_ready) begin
            e_lw = m_link;
            e_ld = m_pc + 48'd4;
          end
        end else begin
          e_fl = 1'b1;
        end
      end
      chk("m_in_ready",  48'(in_ready),       48'(e_rdy));
      chk("m_imm_src",   48'(imm_src),        48'(e_imm));
      chk("m_rd_valid",  48'(redirect_valid), 48'(e_rv));
      chk("m_link_we",   48'(link_we),        48'(e_lw));
      chk("m_link_data", link_data,           e_ld);
      chk("m_flush",     48'(flush),          48'(e_fl));
      if (e_rv) chk("m_rd_pc", redirect_pc, m_target);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    chk("idle_timeout", 48'(in_ready), 48'(1));
  endtask

  task automatic present_branch(input logic [W-1:0] p, input logic [23:0] f,
                                input logic c, input logic l);
    pc        = p;
    instr     = f;
    cond_pass = c;
    is_link   = l;
    in_valid  = 1'b1;
    is_branch = 1'b1;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int nf;

    // Reset values
    rst_n = 1'b0;
    step(2);
    chk("rst_in_ready",  48'(in_ready),       48'(1));
    chk("rst_rd_valid",  48'(redirect_valid), 48'(0));
    chk("rst_rd_pc",     redirect_pc,         48'h0);
    chk("rst_link_we",   48'(link_we),        48'(0));
    chk("rst_link_data", link_data,           48'h0);
    chk("rst_flush",     48'(flush),          48'(0));
    imm_src_req = 2'b01;
    #1;
    chk("rst_imm_pass", 48'(imm_src), 48'(2'b01));
    rst_n = 1'b1;

    // Non-branch: pass-through, no state change
    in_valid  = 1'b1;
    is_branch = 1'b0;
    step(1);
    chk("nb_in_ready", 48'(in_ready), 48'(1));
    chk("nb_imm_src",  48'(imm_src),  48'(2'b01));

    // Taken branch, fetch ready immediately
    redirect_ready = 1'b1;
    present_branch(48'h100, 24'h000010, 1'b1, 1'b0);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    chk("tk_calc_imm",   48'(imm_src),  48'(2'b10));
    chk("tk_calc_stall", 48'(in_ready), 48'(0));
    step(1);
    chk("tk_rd_valid", 48'(redirect_valid), 48'(1));
    chk("tk_rd_pc",    redirect_pc,         48'h148);
    step(1);
    nf = 0;
    while (flush === 1'b1 && nf < 10) begin
      nf++;
      step(1);
    end
    chk("tk_flush_len",   48'(nf),       48'(2));
    chk("tk_ready_again", 48'(in_ready), 48'(1));

    // Branch-link, fetch stalls three cycles
    imm_src_req    = 2'b00;
    redirect_ready = 1'b0;
    present_branch(48'h200, 24'hFFFFFE, 1'b1, 1'b1);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    step(1);
    chk("lk_rd_valid", 48'(redirect_valid), 48'(1));
    chk("lk_rd_pc",    redirect_pc,         48'h200);
    step(3);
    chk("lk_rd_hold",  redirect_pc,         48'h200);
    chk("lk_vld_hold", 48'(redirect_valid), 48'(1));
    chk("lk_we_wait",  48'(link_we),        48'(0));
    redirect_ready = 1'b1;
    #1;
    chk("lk_we",   48'(link_we), 48'(1));
    chk("lk_data", link_data,    48'h204);
    step(1);
    redirect_ready = 1'b0;
    #1;
    chk("lk_we_once", 48'(link_we), 48'(0));
    chk("lk_flush",   48'(flush),   48'(1));
    wait_idle();

    // Not-taken branch
    imm_src_req    = 2'b11;
    redirect_ready = 1'b1;
    present_branch(48'h300, 24'h000010, 1'b0, 1'b1);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    chk("nt_stall",    48'(in_ready),       48'(0));
    chk("nt_calc_imm", 48'(imm_src),        48'(2'b10));
    step(1);
    chk("nt_idle",     48'(in_ready),       48'(1));
    chk("nt_no_rd",    48'(redirect_valid), 48'(0));
    chk("nt_no_flush", 48'(flush),          48'(0));

    // Target wraps modulo 2^48
    present_branch(48'hFFFF_FFFF_FFFC, 24'h000000, 1'b1, 1'b0);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    step(1);
    chk("wr_rd_pc", redirect_pc, 48'h4);
    wait_idle();

    // Reset while offering the redirect
    redirect_ready = 1'b0;
    present_branch(48'h400, 24'h000001, 1'b1, 1'b1);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    step(1);
    chk("rr_pre_valid", 48'(redirect_valid), 48'(1));
    rst_n = 1'b0;
    step(1);
    redirect_ready = 1'b1;
    #1;
    chk("rr_rd_valid", 48'(redirect_valid), 48'(0));
    chk("rr_link_we",  48'(link_we),        48'(0));
    chk("rr_flush",    48'(flush),          48'(0));
    chk("rr_in_ready", 48'(in_ready),       48'(1));
    rst_n = 1'b1;
    step(1);
    chk("rr_post_flush", 48'(flush),          48'(0));
    chk("rr_post_valid", 48'(redirect_valid), 48'(0));

    // Reset during the flush
    present_branch(48'h500, 24'h000002, 1'b1, 1'b1);
    step(1);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    step(2);
    chk("rf_pre_flush", 48'(flush), 48'(1));
    rst_n = 1'b0;
    step(1);
    chk("rf_flush",    48'(flush),          48'(0));
    chk("rf_rd_valid", 48'(redirect_valid), 48'(0));
    chk("rf_link_we",  48'(link_we),        48'(0));
    rst_n = 1'b1;

    // Back-to-back branches held by decode
    imm_src_req    = 2'b01;
    redirect_ready = 1'b1;
    present_branch(48'h600, 24'h000004, 1'b1, 1'b1);
    step(12);
    in_valid  = 1'b0;
    is_branch = 1'b0;
    wait_idle();
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
